// File: rtl/dmsc_vline_buf_if.sv
// Handshake and window bus of the vertical line buffer.
// The block takes the slave view; the pixel source and the window consumer together take the master view.
interface dmsc_vline_buf_if #(
  parameter int DATA_WIDTH = 72
);
  // Input side:  a pixel moves on an edge where u_i_ready && i_i_ready.
  // Output side: a window moves on an edge where i_r_ready && u_r_ready.
  logic                      u_i_ready;
  logic                      u_r_ready;
  logic [DATA_WIDTH-1:0]     data_in;
  logic [3*DATA_WIDTH-1:0]   r0;
  logic [3*DATA_WIDTH-1:0]   r1;
  logic [3*DATA_WIDTH-1:0]   r2;
  logic [11:0]               center_x;
  logic [11:0]               center_y;
  logic                      i_i_ready;
  logic                      i_r_ready;

  modport master (
    output u_i_ready, u_r_ready, data_in,
    input  r0, r1, r2, center_x, center_y, i_i_ready, i_r_ready
  );

  modport slave (
    input  u_i_ready, u_r_ready, data_in,
    output r0, r1, r2, center_x, center_y, i_i_ready, i_r_ready
  );
endinterface

// File: rtl/dmsc_vline_buf.sv
// 3x3 window generator: two line memories plus per-row 2-deep shift registers turn a
// raster pixel stream into one registered window per accepted pixel once x>=2 and y>=2.
module dmsc_vline_buf #(
  parameter int DATA_WIDTH   = 72,
  parameter int LINE_WIDTH   = 4096,
  parameter int FRAME_HEIGHT = 3072
) (
  input logic            clock,
  input logic            reset,
  dmsc_vline_buf_if.slave bus
);

  localparam int DW = DATA_WIDTH;
  localparam int XW = $clog2(LINE_WIDTH);
  localparam int YW = $clog2(FRAME_HEIGHT);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [XW-1:0]   r_x;
  logic [YW-1:0]   r_y;

  logic [DW-1:0]   r_l1 [LINE_WIDTH];
  logic [DW-1:0]   r_l2 [LINE_WIDTH];

  logic [2*DW-1:0] r_top_sh;
  logic [2*DW-1:0] r_mid_sh;
  logic [2*DW-1:0] r_bot_sh;

  logic [3*DW-1:0] r_r0;
  logic [3*DW-1:0] r_r1;
  logic [3*DW-1:0] r_r2;
  logic [11:0]     r_cx;
  logic [11:0]     r_cy;

  logic            w_out_valid;
  logic            w_in_ready;
  logic            w_accept;
  logic            w_consume;
  logic            w_win;
  logic            w_x_last;
  logic            w_y_last;
  logic [DW-1:0]   w_l1_rd;
  logic [DW-1:0]   w_l2_rd;
  logic [XW-1:0]   w_cx;
  logic [YW-1:0]   w_cy;

  assign w_out_valid = (r_state == ST_FULL);
  assign w_in_ready  = !w_out_valid || bus.u_r_ready;
  assign w_accept    = bus.u_i_ready && w_in_ready;
  assign w_consume   = w_out_valid && bus.u_r_ready;
  assign w_x_last    = (r_x == XW'(LINE_WIDTH - 1));
  assign w_y_last    = (r_y == YW'(FRAME_HEIGHT - 1));

  // Rows y-2 and y-1 are only meaningful from line 2 on, which also hides stale
  // memory contents left behind by the previous frame.
  assign w_win       = w_accept && (r_x >= XW'(2)) && (r_y >= YW'(2));

  // Read-before-write: the old contents feed the window in the same cycle they are replaced.
  assign w_l1_rd     = r_l1[r_x];
  assign w_l2_rd     = r_l2[r_x];
  assign w_cx        = r_x - XW'(1);
  assign w_cy        = r_y - YW'(1);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A new window takes priority over a consume, so back-to-back windows keep valid high.
  always_comb begin
    w_state_nxt = r_state;
    if (w_win) begin
      w_state_nxt = ST_FULL;
    end else if (w_consume) begin
      w_state_nxt = ST_EMPTY;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_x <= '0;
      r_y <= '0;
    end else if (w_accept) begin
      if (w_x_last) begin
        r_x <= '0;
        r_y <= w_y_last ? '0 : r_y + YW'(1);
      end else begin
        r_x <= r_x + XW'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && w_accept) begin
      r_l2[r_x] <= w_l1_rd;
      r_l1[r_x] <= bus.data_in;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_top_sh <= '0;
      r_mid_sh <= '0;
      r_bot_sh <= '0;
    end else if (w_accept) begin
      r_top_sh <= {r_top_sh[DW-1:0], w_l2_rd};
      r_mid_sh <= {r_mid_sh[DW-1:0], w_l1_rd};
      r_bot_sh <= {r_bot_sh[DW-1:0], bus.data_in};
    end
  end

  // Oldest column lands in the top slice: {x-2, x-1, x}.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_r0 <= '0;
      r_r1 <= '0;
      r_r2 <= '0;
      r_cx <= '0;
      r_cy <= '0;
    end else if (w_win) begin
      r_r0 <= {r_top_sh, w_l2_rd};
      r_r1 <= {r_mid_sh, w_l1_rd};
      r_r2 <= {r_bot_sh, bus.data_in};
      r_cx <= 12'(w_cx);
      r_cy <= 12'(w_cy);
    end
  end

  assign bus.r0        = r_r0;
  assign bus.r1        = r_r1;
  assign bus.r2        = r_r2;
  assign bus.center_x  = r_cx;
  assign bus.center_y  = r_cy;
  assign bus.i_i_ready = w_in_ready;
  assign bus.i_r_ready = w_out_valid;

endmodule

// File: tb/tb_dmsc_vline_buf.sv
// Bench for dmsc_vline_buf on an 8x6 frame: frame-image reference model feeding an
// expected-window queue, with an independent monitor popping on every consumed window.
module tb_dmsc_vline_buf;

  localparam int DW = 16;
  localparam int LW = 8;
  localparam int FH = 6;
  localparam int W  = 9 * DW + 24;

  logic clock = 1'b0;
  logic reset = 1'b1;

  always #5 clock = ~clock;

  dmsc_vline_buf_if #(.DATA_WIDTH(DW)) bus ();

  dmsc_vline_buf #(
    .DATA_WIDTH  (DW),
    .LINE_WIDTH  (LW),
    .FRAME_HEIGHT(FH)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  int            n_checks = 0;
  int            n_errors = 0;
  int            win_cnt  = 0;
  logic [W-1:0]  exp_q[$];
  logic [W-1:0]  last_win = '0;

  logic [DW-1:0] frm [FH][LW];
  int            mx = 0;
  int            my = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] cur_out();
    return {bus.r0, bus.r1, bus.r2, bus.center_x, bus.center_y};
  endfunction

  function automatic logic [W-1:0] idx_win(input int x, input int y);
    logic [W-1:0] w;
    w = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        w = {w[W-DW-1:0], DW'((y - 2 + r) * LW + (x - 2 + c))};
      end
    end
    return {w[9*DW-1:0], 12'(x - 1), 12'(y - 1)};
  endfunction

  // Reference model: the frame as a picture; every accept at (x>=2, y>=2) expects the
  // 3x3 neighbourhood ending at that pixel.
  always @(negedge clock) begin
    if (reset) begin
      mx = 0;
      my = 0;
      exp_q.delete();
    end else if (bus.u_i_ready && bus.i_i_ready) begin
      frm[my][mx] = bus.data_in;
      if (mx >= 2 && my >= 2) begin
        exp_q.push_back({frm[my-2][mx-2], frm[my-2][mx-1], frm[my-2][mx],
                         frm[my-1][mx-2], frm[my-1][mx-1], frm[my-1][mx],
                         frm[my][mx-2],   frm[my][mx-1],   frm[my][mx],
                         12'(mx - 1), 12'(my - 1)});
      end
      mx++;
      if (mx == LW) begin
        mx = 0;
        my++;
        if (my == FH) my = 0;
      end
    end
  end

  // Monitor: compares each window at the moment it is consumed.
  always @(negedge clock) begin
    if (!reset && bus.i_r_ready && bus.u_r_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_window: got %h expected none", cur_out());
      end else begin
        check("window", cur_out(), exp_q.pop_front());
      end
      win_cnt++;
      last_win = cur_out();
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    bus.u_i_ready = 1'b0;
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.u_i_ready = 1'b0;
    repeat (n) tick();
  endtask

  // Offers one pixel and returns just after the edge that accepted it.
  task automatic send(input logic [DW-1:0] d);
    logic ok;
    ok = 1'b0;
    bus.u_i_ready = 1'b1;
    bus.data_in   = d;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clock);
      ok = bus.i_i_ready;
      @(posedge clock);
      #1;
    end
    bus.u_i_ready = 1'b0;
    if (!ok) begin
      n_checks++;
      n_errors++;
      $display("FAIL send_timeout: pixel %0d not accepted in 50 cycles", d);
    end
  endtask

  task automatic warmup_and_first();
    for (int i = 0; i < 18; i++) begin
      send(DW'(i));
      check("warmup_i_r_ready", W'(bus.i_r_ready), W'(0));
    end
    send(DW'(18));
    check("first_i_r_ready", W'(bus.i_r_ready), W'(1));
    check("first_window", cur_out(), idx_win(2, 2));
    check("first_r0", W'(bus.r0), W'({16'd0, 16'd1, 16'd2}));
    check("first_r2", W'(bus.r2), W'({16'd16, 16'd17, 16'd18}));
  endtask

  initial begin
    logic [W-1:0] snap;
    bus.u_i_ready = 1'b0;
    bus.u_r_ready = 1'b1;
    bus.data_in   = '0;

    do_reset();
    check("rst_r0", W'(bus.r0), W'(0));
    check("rst_r1", W'(bus.r1), W'(0));
    check("rst_r2", W'(bus.r2), W'(0));
    check("rst_center_x", W'(bus.center_x), W'(0));
    check("rst_center_y", W'(bus.center_y), W'(0));
    check("rst_i_i_ready", W'(bus.i_i_ready), W'(1));
    check("rst_i_r_ready", W'(bus.i_r_ready), W'(0));

    warmup_and_first();

    // Backpressure with a window held and junk on data_in.
    bus.u_r_ready = 1'b0;
    bus.u_i_ready = 1'b1;
    snap = cur_out();
    repeat (3) begin
      bus.data_in = DW'($urandom);
      @(negedge clock);
      check("stall_i_i_ready", W'(bus.i_i_ready), W'(0));
      check("stall_i_r_ready", W'(bus.i_r_ready), W'(1));
      check("stall_hold", cur_out(), snap);
      @(posedge clock);
      #1;
    end
    bus.u_r_ready = 1'b1;
    send(DW'(19));
    check("after_stall_r2", W'(bus.r2), W'({16'd17, 16'd18, 16'd19}));

    for (int i = 20; i < 66; i++) send(DW'(i));
    @(negedge clock);
    check("frame1_windows", W'(win_cnt), W'(24));
    check("frame1_last", last_win, idx_win(7, 5));
    @(posedge clock);
    #1;
    for (int i = 66; i < 96; i++) send(DW'(i));
    idle(3);
    check("frame2_windows", W'(win_cnt), W'(48));
    check("drain_q", W'(exp_q.size()), W'(0));

    // Random traffic on both sides.
    for (int c = 0; c < 400; c++) begin
      bus.u_i_ready = 1'($urandom_range(0, 1));
      bus.data_in   = DW'($urandom);
      bus.u_r_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    bus.u_r_ready = 1'b1;
    idle(3);
    check("random_drain_q", W'(exp_q.size()), W'(0));

    // Mid-frame reset with a window pending.
    do_reset();
    for (int i = 0; i <= 30; i++) send(DW'(i));
    bus.u_r_ready = 1'b0;
    check("pre_reset_pending", W'(bus.i_r_ready), W'(1));
    do_reset();
    check("midreset_i_r_ready", W'(bus.i_r_ready), W'(0));
    check("midreset_i_i_ready", W'(bus.i_i_ready), W'(1));
    bus.u_r_ready = 1'b1;
    warmup_and_first();
    idle(3);
    check("final_drain_q", W'(exp_q.size()), W'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    n_errors++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
